c1_scratch_resp: RTL

C1_SCRATCH_RESP -- requirements
Module: c1_scratch_resp

---
 rtl/c1_scratch_resp.sv | 216 +++++++++++++++++++++
 1 files changed

// File: rtl/c1_scratch_resp.sv
// Scratchpad responder on the shared c1/d1/a1 bus: LINES x 16-byte store with
// READ8/16/32, WRITE8/16/32 and INVALIDATE_LINE. Optional C1_SCRATCH_RESP_DUMP_EN adds a dump port.
module c1_scratch_resp #(
   parameter int WAIT_CYCLES = 4,
   parameter int LINES       = 64
) (
   input  logic        clk,
   input  logic        reset,
`ifdef C1_SCRATCH_RESP_DUMP_EN
   input  logic        dump,
`endif
   input  logic [13:0] a1,
   inout  wire  [15:0] d1,
   inout  wire  [2:0]  c1,
   output logic        busy
);

   localparam int LW = $clog2(LINES);

   localparam logic [2:0] CMD_NOP      = 3'd0;
   localparam logic [2:0] CMD_READ8    = 3'd1;
   localparam logic [2:0] CMD_READ16   = 3'd2;
   localparam logic [2:0] CMD_READ32   = 3'd3;
   localparam logic [2:0] CMD_INVAL    = 3'd4;
   localparam logic [2:0] CMD_WRITE8   = 3'd5;
   localparam logic [2:0] CMD_WRITE16  = 3'd6;
   localparam logic [2:0] CMD_WRITE32  = 3'd7;
   localparam logic [2:0] C1_RESPONSE  = 3'd7;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      ADDR2   = 3'd1,
      TURN    = 3'd2,
      WAIT    = 3'd3,
      RESP    = 3'd4,
      RESP2   = 3'd5,
      RELEASE = 3'd6
   } state_t;

   state_t      state_r;
   logic [2:0]  cmd_r;
   logic [13:0] line_r;
   logic [3:0]  off_r;
   logic [15:0] data_lo_r;
   logic [15:0] data_hi_r;
   logic [3:0]  wait_cnt_r;
   logic        c1_oe_r;
   logic [2:0]  c1_out_r;
   logic        d1_oe_r;
   logic [15:0] d1_out_r;

   logic [7:0]  mem_r [LINES*16];

   logic [LW-1:0] line_idx_s;
   logic [3:0]    base_s;
   logic          is_read_s;
   logic          wr_en_s;
   logic [15:0]   rd_lo_s;
   logic [15:0]   rd_hi_s;

   // Access offsets are aligned down to the access size, so nothing crosses a line.
   function automatic logic [3:0] align_off(input logic [2:0] cmd, input logic [3:0] off);
      case (cmd)
         CMD_READ8,  CMD_WRITE8:  return off;
         CMD_READ16, CMD_WRITE16: return {off[3:1], 1'b0};
         CMD_READ32, CMD_WRITE32: return {off[3:2], 2'b00};
         default:                 return off;
      endcase
   endfunction

   assign c1 = c1_oe_r ? c1_out_r : 3'bzzz;
   assign d1 = d1_oe_r ? d1_out_r : 16'hzzzz;

   // Upper line-address bits alias onto the stored lines.
   assign line_idx_s = LW'(line_r % 14'(LINES));
   assign base_s     = align_off(cmd_r, off_r);
   assign is_read_s  = (cmd_r == CMD_READ8) || (cmd_r == CMD_READ16) || (cmd_r == CMD_READ32);
   assign wr_en_s    = reset && (state_r == RESP) &&
                       ((cmd_r == CMD_WRITE8) || (cmd_r == CMD_WRITE16) || (cmd_r == CMD_WRITE32));

   // Little-endian read lanes for the current access
   always_comb begin
      rd_lo_s = 16'h0000;
      rd_hi_s = {mem_r[{line_idx_s, base_s | 4'd3}], mem_r[{line_idx_s, base_s | 4'd2}]};
      case (cmd_r)
         CMD_READ8:  rd_lo_s = {8'h00, mem_r[{line_idx_s, base_s}]};
         CMD_READ16,
         CMD_READ32: rd_lo_s = {mem_r[{line_idx_s, base_s | 4'd1}], mem_r[{line_idx_s, base_s}]};
         default:    rd_lo_s = 16'h0000;
      endcase
   end

   // Bus protocol FSM with registered drivers and busy
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_r    <= IDLE;
         cmd_r      <= CMD_NOP;
         line_r     <= 14'd0;
         off_r      <= 4'd0;
         data_lo_r  <= 16'h0000;
         data_hi_r  <= 16'h0000;
         wait_cnt_r <= 4'd0;
         c1_oe_r    <= 1'b0;
         c1_out_r   <= CMD_NOP;
         d1_oe_r    <= 1'b0;
         d1_out_r   <= 16'h0000;
         busy       <= 1'b0;
      end else begin
         case (state_r)
            IDLE: begin
               if (c1 != CMD_NOP) begin
                  cmd_r     <= c1;
                  line_r    <= a1;
                  data_lo_r <= d1;
                  busy      <= 1'b1;
                  state_r   <= ADDR2;
               end
            end
            ADDR2: begin
               off_r     <= a1[3:0];
               data_hi_r <= d1;
               state_r   <= TURN;
            end
            TURN: begin
               c1_oe_r    <= 1'b1;
               c1_out_r   <= CMD_NOP;
               wait_cnt_r <= 4'(WAIT_CYCLES);
               state_r    <= WAIT;
            end
            WAIT: begin
               if (wait_cnt_r == 4'd1) begin
                  wait_cnt_r <= 4'd0;
                  c1_out_r   <= C1_RESPONSE;
                  d1_oe_r    <= is_read_s;
                  d1_out_r   <= is_read_s ? rd_lo_s : 16'h0000;
                  state_r    <= RESP;
               end else begin
                  wait_cnt_r <= wait_cnt_r - 4'd1;
               end
            end
            RESP: begin
               if (cmd_r == CMD_READ32) begin
                  d1_out_r <= rd_hi_s;
                  state_r  <= RESP2;
               end else begin
                  c1_oe_r  <= 1'b0;
                  c1_out_r <= CMD_NOP;
                  d1_oe_r  <= 1'b0;
                  d1_out_r <= 16'h0000;
                  busy     <= 1'b0;
                  state_r  <= RELEASE;
               end
            end
            RESP2: begin
               c1_oe_r  <= 1'b0;
               c1_out_r <= CMD_NOP;
               d1_oe_r  <= 1'b0;
               d1_out_r <= 16'h0000;
               busy     <= 1'b0;
               state_r  <= RELEASE;
            end
            RELEASE: begin
               state_r <= IDLE;
            end
            default: begin
               c1_oe_r <= 1'b0;
               d1_oe_r <= 1'b0;
               busy    <= 1'b0;
               state_r <= IDLE;
            end
         endcase
      end
   end

   // Storage commit on the edge that ends RESP; contents survive reset
   always_ff @(posedge clk) begin
      if (wr_en_s) begin
         mem_r[{line_idx_s, base_s}] <= data_lo_r[7:0];
         if (cmd_r != CMD_WRITE8) begin
            mem_r[{line_idx_s, base_s | 4'd1}] <= data_lo_r[15:8];
         end
         if (cmd_r == CMD_WRITE32) begin
            mem_r[{line_idx_s, base_s | 4'd2}] <= data_hi_r[7:0];
            mem_r[{line_idx_s, base_s | 4'd3}] <= data_hi_r[15:8];
         end
      end
   end

`ifdef C1_SCRATCH_RESP_DUMP_EN
   logic dump_q_r;

   function automatic logic [127:0] line_word(input int idx);
      logic [127:0] w;
      w = 128'd0;
      for (int b = 0; b < 16; b++) begin
         w[b*8 +: 8] = mem_r[idx*16 + b];
      end
      return w;
   endfunction

   // Print the whole store on a rising edge of dump
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         dump_q_r <= 1'b0;
      end else begin
         dump_q_r <= dump;
         if (dump && !dump_q_r) begin
            for (int i = 0; i < LINES; i++) begin
               $display("%0d %032h", i, line_word(i));
            end
         end
      end
   end
`endif

endmodule
